// File: rtl/cpu_pkg.sv
// Shared CPU constants for the decode/operand-fetch slice.
//   DATA_W   operand / register width
//   REG_W    register index width (R0 hardwired to zero)
//   PEND_W   per-register pending-write counter width
//   NUM_REGS number of architectural registers
//   R0       index of the hardwired-zero register
//   PEND_MAX saturation value of a pending-write counter
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 4;
    localparam int PEND_W   = 2;
    localparam int NUM_REGS = 1 << REG_W;

    localparam logic [REG_W-1:0]  R0       = {REG_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   inc_en_i/idx_i    a write to idx has been issued (R0 ignored)
//   dec_en_i/idx_i    a write to idx retires this cycle (R0 ignored)
//   q1_idx_i/q2_idx_i source indices to test for outstanding writes
//   qd_idx_i          destination index to test for counter saturation
//   busy1_o/busy2_o   source still has a write in flight that is not retiring now
//   full_o            destination counter saturated and not retiring now
//   sb_err_o          sticky: a retire arrived for a register with no pending write
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en_i,
    input  logic [REG_W-1:0] inc_idx_i,
    input  logic             dec_en_i,
    input  logic [REG_W-1:0] dec_idx_i,
    input  logic [REG_W-1:0] q1_idx_i,
    input  logic [REG_W-1:0] q2_idx_i,
    input  logic [REG_W-1:0] qd_idx_i,
    output logic             busy1_o,
    output logic             busy2_o,
    output logic             full_o,
    output logic             sb_err_o
);

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic              err_q;
    logic              err_d;
    logic              inc_s;
    logic              dec_s;

    // R0 is never tracked, so both update requests are masked for it here.
    assign inc_s = inc_en_i && (inc_idx_i != R0);
    assign dec_s = dec_en_i && (dec_idx_i != R0);

    // A source whose last pending write retires this cycle is served by the
    // register-file bypass, so it is not considered busy.
    assign busy1_o = (pend_q[q1_idx_i] != {PEND_W{1'b0}}) &&
                     !((pend_q[q1_idx_i] == PEND_W'(1)) && dec_s && (dec_idx_i == q1_idx_i));
    assign busy2_o = (pend_q[q2_idx_i] != {PEND_W{1'b0}}) &&
                     !((pend_q[q2_idx_i] == PEND_W'(1)) && dec_s && (dec_idx_i == q2_idx_i));
    // A retire to the same register frees a slot in the counter this cycle.
    assign full_o  = (pend_q[qd_idx_i] == PEND_MAX) && !(dec_s && (dec_idx_i == qd_idx_i));
    assign sb_err_o = err_q;

    // Next-state counters: retire applied first, then issue, so a same-cycle
    // issue and retire on one register leaves its count unchanged.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (dec_s) begin
            if (pend_q[dec_idx_i] == {PEND_W{1'b0}}) begin
                err_d = 1'b1;
            end else begin
                pend_d[dec_idx_i] = pend_q[dec_idx_i] - PEND_W'(1);
            end
        end else begin
            err_d = err_q;
        end
        if (inc_s) begin
            pend_d[inc_idx_i] = pend_d[inc_idx_i] + PEND_W'(1);
        end else begin
            err_d = err_d;
        end
    end

    // Counter and sticky-error registers; reset discards all in-flight state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= {PEND_W{1'b0}};
            end
            err_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand reader with ID/EX output slot and RAW scoreboard.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             decoded-instruction handshake (issue = both high)
//   in_src1/2, in_use1/2          source indices and their use flags
//   in_dst, in_wen                destination index and write enable
//   rf_src1/2, rf_data1/2         register-file read port (same-cycle data)
//   wb_wen, wb_dst                writeback retire notification
//   out_valid/out_ready           ID/EX slot handshake
//   out_op1/2, out_dst, out_wen   captured slot contents
//   sb_err                        sticky scoreboard underflow error
module operand_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_src1,
    input  logic [REG_W-1:0]  in_src2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              in_wen,
    output logic [REG_W-1:0]  rf_src1,
    output logic [REG_W-1:0]  rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_wen,
    input  logic [REG_W-1:0]  wb_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [REG_W-1:0]  out_dst,
    output logic              out_wen,
    output logic              sb_err
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic              wen_q, wen_d;

    logic slot_free_s;
    logic hazard_s;
    logic structural_s;
    logic issue_s;
    logic busy1_s;
    logic busy2_s;
    logic full_s;

    // Register-file addresses follow the decoded sources with no latency.
    assign rf_src1 = in_src1;
    assign rf_src2 = in_src2;

    assign slot_free_s  = !valid_q || out_ready;
    assign hazard_s     = (in_use1 && (in_src1 != R0) && busy1_s) ||
                          (in_use2 && (in_src2 != R0) && busy2_s);
    assign structural_s = in_wen && (in_dst != R0) && full_s;
    assign in_ready     = slot_free_s && !hazard_s && !structural_s;
    assign issue_s      = in_valid && in_ready;

    reg_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en_i  (issue_s && in_wen),
        .inc_idx_i (in_dst),
        .dec_en_i  (wb_wen),
        .dec_idx_i (wb_dst),
        .q1_idx_i  (in_src1),
        .q2_idx_i  (in_src2),
        .qd_idx_i  (in_dst),
        .busy1_o   (busy1_s),
        .busy2_o   (busy2_s),
        .full_o    (full_s),
        .sb_err_o  (sb_err)
    );

    // Slot next state: load on issue, drop valid on consume, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        dst_d   = dst_q;
        wen_d   = wen_q;
        if (issue_s) begin
            valid_d = 1'b1;
            op1_d   = rf_data1;
            op2_d   = rf_data2;
            dst_d   = in_dst;
            wen_d   = in_wen;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // ID/EX slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= {DATA_W{1'b0}};
            op2_q   <= {DATA_W{1'b0}};
            dst_q   <= {REG_W{1'b0}};
            wen_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            dst_q   <= dst_d;
            wen_q   <= wen_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_dst   = dst_q;
    assign out_wen   = wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [REG_W-1:0]  in_src1, in_src2, in_dst;
    logic              in_use1, in_use2, in_wen;
    logic [REG_W-1:0]  rf_src1, rf_src2;
    logic [DATA_W-1:0] rf_data1, rf_data2;
    logic              wb_wen;
    logic [REG_W-1:0]  wb_dst;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_op1, out_op2;
    logic [REG_W-1:0]  out_dst;
    logic              out_wen, sb_err;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
        .in_dst(in_dst), .in_wen(in_wen),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_wen(wb_wen), .wb_dst(wb_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst), .out_wen(out_wen),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: abstract pipeline-slot contents and in-flight write counts.
    int                m_pend [16];
    bit                m_err, m_valid, m_wen;
    logic [DATA_W-1:0] m_op1, m_op2;
    logic [REG_W-1:0]  m_dst;
    int                PMAX = (1 << PEND_W) - 1;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_err = 0; m_valid = 0; m_wen = 0; m_op1 = '0; m_op2 = '0; m_dst = '0;
    endfunction

    function automatic bit src_blocked(input bit use_it, input int s);
        if (!use_it || s == 0) return 0;
        if (m_pend[s] == 0) return 0;
        if (m_pend[s] == 1 && wb_wen && int'(wb_dst) == s) return 0;
        return 1;
    endfunction

    function automatic bit model_ready();
        bit st;
        st = in_wen && in_dst != 0 && m_pend[in_dst] == PMAX && !(wb_wen && wb_dst == in_dst);
        return (!m_valid || out_ready) && !src_blocked(in_use1, int'(in_src1))
               && !src_blocked(in_use2, int'(in_src2)) && !st;
    endfunction

    task automatic tick();
        bit iss;
        iss = in_valid && model_ready();
        @(posedge clk);
        if (wb_wen && wb_dst != 0) begin
            if (m_pend[wb_dst] == 0) m_err = 1;
            else m_pend[wb_dst]--;
        end
        if (iss) begin
            m_valid = 1; m_op1 = rf_data1; m_op2 = rf_data2; m_dst = in_dst; m_wen = in_wen;
            if (in_wen && in_dst != 0) m_pend[in_dst]++;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_use1 = 0; in_use2 = 0; in_wen = 0;
        in_src1 = '0; in_src2 = '0; in_dst = '0;
        wb_wen = 0; wb_dst = '0; out_ready = 1;
        rf_data1 = DATA_W'($urandom); rf_data2 = DATA_W'($urandom);
    endtask

    task automatic instr(input int s1, input int s2, input bit u1, input bit u2,
                         input int d, input bit w);
        in_valid = 1; in_src1 = REG_W'(s1); in_src2 = REG_W'(s2);
        in_use1 = u1; in_use2 = u2; in_dst = REG_W'(d); in_wen = w;
        rf_data1 = DATA_W'($urandom); rf_data2 = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        idle(); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_op1 !== 16'h0 || out_op2 !== 16'h0) begin n_bad++; $display("FAIL reset_ops: got %h/%h want 0/0", out_op1, out_op2); end
        n_cmp++; if (out_dst !== 4'h0 || out_wen !== 1'b0) begin n_bad++; $display("FAIL reset_dst: got %h/%b want 0/0", out_dst, out_wen); end
        n_cmp++; if (sb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", sb_err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) instr(2, 3, 1, 1, 1, 1); else instr(5, 6, 1, 1, 4, 1);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
            n_cmp++; if (rf_src1 !== in_src1 || rf_src2 !== in_src2) begin n_bad++; $display("FAIL b2b_addr%0d: got %h/%h want %h/%h", k, rf_src1, rf_src2, in_src1, in_src2); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_op1 !== m_op1 || out_op2 !== m_op2 || out_dst !== m_dst) begin
                n_bad++; $display("FAIL b2b_slot%0d: got %b %h %h %h want 1 %h %h %h", k, out_valid, out_op1, out_op2, out_dst, m_op1, m_op2, m_dst); end
        end
        idle(); wb_wen = 1; wb_dst = 4'd1; tick();
        wb_dst = 4'd4; tick(); idle(); tick();
    endtask

    task automatic test_raw_stall();
        instr(0, 0, 0, 0, 5, 1); tick();
        instr(5, 2, 1, 0, 8, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall%0d: got %b want 0", k, in_ready); end
            tick();
        end
        wb_wen = 1; wb_dst = 4'd5; rf_data1 = 16'hBEEF; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_op1 !== 16'hBEEF) begin n_bad++; $display("FAIL raw_bypass_op: got %b %h want 1 beef", out_valid, out_op1); end
        idle(); tick();
    endtask

    task automatic test_r0();
        instr(1, 1, 0, 0, 0, 1); tick();
        instr(0, 0, 1, 1, 3, 0); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_op1 !== m_op1) begin n_bad++; $display("FAIL r0_issue: got %b %h want 1 %h", out_valid, out_op1, m_op1); end
        idle(); tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            instr(0, 0, 0, 0, 7, 1); #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sat_fill%0d: got %b want 1", k, in_ready); end
            tick();
        end
        instr(0, 0, 0, 0, 7, 1);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL sat_stall%0d: got %b want 0", k, in_ready); end
            tick();
        end
        wb_wen = 1; wb_dst = 4'd7; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sat_release: got %b want 1", in_ready); end
        tick();
        idle(); wb_wen = 1; wb_dst = 4'd7;
        repeat (3) tick();
        idle(); instr(7, 7, 1, 1, 2, 0); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sat_drained: got %b want 1", in_ready); end
        tick(); idle(); tick();
    endtask

    task automatic test_backpressure_err();
        logic [DATA_W-1:0] held1, held2;
        instr(1, 2, 1, 1, 8, 0); out_ready = 0; tick();
        held1 = m_op1; held2 = m_op2;
        instr(3, 4, 1, 1, 10, 1); out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin wb_wen = 1; wb_dst = 4'd9; end else wb_wen = 0;
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0", k, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_op1 !== held1 || out_op2 !== held2) begin
                n_bad++; $display("FAIL bp_hold%0d: got %b %h %h want 1 %h %h", k, out_valid, out_op1, out_op2, held1, held2); end
        end
        n_cmp++; if (sb_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", sb_err); end
        idle(); repeat (3) tick();
        n_cmp++; if (sb_err !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL err_sticky: got %b/%b want 1/0", sb_err, out_valid); end
    endtask

    task automatic test_reset_midstream();
        instr(0, 0, 0, 0, 3, 1); tick();
        instr(0, 0, 0, 0, 3, 1); tick();
        idle(); out_ready = 0; #2;
        rst = 1; #1;
        model_reset();
        n_cmp++; if (out_valid !== 1'b0 || sb_err !== 1'b0 || out_op1 !== 16'h0 || out_dst !== 4'h0) begin
            n_bad++; $display("FAIL rst_mid: got %b %b %h %h want 0 0 0 0", out_valid, sb_err, out_op1, out_dst); end
        @(posedge clk); #1; rst = 0;
        instr(3, 3, 1, 1, 3, 1); out_ready = 1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_pend_clear: got %b want 1", in_ready); end
        tick(); idle(); wb_wen = 1; wb_dst = 4'd3; tick(); idle(); tick();
    endtask

    task automatic test_random();
        int cand [$];
        for (int cyc = 0; cyc < 400; cyc++) begin
            instr($urandom_range(15), $urandom_range(15), $urandom_range(1), $urandom_range(1),
                  $urandom_range(15), $urandom_range(1));
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            cand.delete();
            for (int r = 1; r < 16; r++) if (m_pend[r] > 0) cand.push_back(r);
            wb_wen = 0; wb_dst = '0;
            if (cand.size() > 0 && $urandom_range(1) == 1) begin
                wb_wen = 1; wb_dst = REG_W'(cand[$urandom_range(cand.size() - 1)]);
            end
            #1;
            n_cmp++; if (in_ready !== model_ready()) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, model_ready()); end
            tick();
            n_cmp++; if (out_valid !== m_valid || sb_err !== m_err) begin
                n_bad++; $display("FAIL rnd_ctrl@%0d: got %b/%b want %b/%b", cyc, out_valid, sb_err, m_valid, m_err); end
            if (m_valid) begin
                n_cmp++; if (out_op1 !== m_op1 || out_op2 !== m_op2 || out_dst !== m_dst || out_wen !== m_wen) begin
                    n_bad++; $display("FAIL rnd_slot@%0d: got %h %h %h %b want %h %h %h %b", cyc,
                                      out_op1, out_op2, out_dst, out_wen, m_op1, m_op2, m_dst, m_wen); end
            end
        end
    endtask

    initial begin
        rst = 1; idle(); model_reset();
        repeat (2) @(posedge clk);
        #1; rst = 0;
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_r0();
        test_saturation();
        test_backpressure_err();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
